// File: rtl/loadable_updown_counter_if.sv
// Control/status bundle for loadable_updown_counter: commands in, count and flags out.
interface loadable_updown_counter_if #(
    parameter int unsigned N = 4
);
    logic         EN;
    logic         CLR;
    logic         LOAD;
    logic [N-1:0] LOAD_VAL;
    logic [N-1:0] LIMIT;
    logic         DIR;
    logic [1:0]   MODE;
    logic [N-1:0] COUNT;
    logic         DONE;
    logic         TC;
    logic         RUNNING;

    modport master (
        output EN, CLR, LOAD, LOAD_VAL, LIMIT, DIR, MODE,
        input  COUNT, DONE, TC, RUNNING
    );

    modport slave (
        input  EN, CLR, LOAD, LOAD_VAL, LIMIT, DIR, MODE,
        output COUNT, DONE, TC, RUNNING
    );
endinterface

// File: rtl/loadable_updown_counter.sv
// Prescaled up/down counter with load, clear, clamp-to-limit and wrap/saturate/one-shot modes.
module loadable_updown_counter #(
    parameter int unsigned  N        = 4,
    parameter logic [N-1:0] START    = '0,
    parameter int unsigned  STEP     = 1,
    parameter int unsigned  PRESCALE = 1
) (
    input logic                    CLK,
    input logic                    RST_N,
    loadable_updown_counter_if.slave bus
);

    localparam int unsigned  PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [N:0]    STEP_X   = (N+1)'(STEP);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SAT      = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_e;

    typedef enum logic {
        ST_EXPIRED = 1'b0,
        ST_RUN     = 1'b1
    } run_e;

    run_e          state_q, state_d;
    logic [N-1:0]  count_q, count_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tc_q, tc_d;

    mode_e         mode;
    logic          active;
    logic          tick;
    logic          at_or_past;
    logic          land;
    logic [N:0]    sum;
    logic [N:0]    diff;

    assign mode   = mode_e'(bus.MODE);
    assign active = bus.EN && (state_q == ST_RUN);
    assign tick   = active && (pre_q == PRE_LAST);
    assign sum    = {1'b0, count_q} + STEP_X;
    assign diff   = {1'b0, count_q} - STEP_X;

    // A count already beyond LIMIT in the counting direction behaves as if it sat on LIMIT.
    assign at_or_past = (count_q == bus.LIMIT)
                     || (!bus.DIR && (count_q > bus.LIMIT))
                     || ( bus.DIR && (count_q < bus.LIMIT));

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        state_d = state_q;
        land    = 1'b0;

        if (bus.CLR) begin
            count_d = START;
            pre_d   = '0;
            state_d = ST_RUN;
        end else if (bus.LOAD) begin
            count_d = bus.LOAD_VAL;
            pre_d   = '0;
            state_d = ST_RUN;
        end else if (tick) begin
            pre_d = '0;
            if (at_or_past) begin
                unique case (mode)
                    MODE_SAT:     count_d = count_q;
                    MODE_ONESHOT: state_d = ST_EXPIRED;
                    default:      count_d = START;
                endcase
            end else if (!bus.DIR) begin
                if (sum >= {1'b0, bus.LIMIT}) land    = 1'b1;
                else                          count_d = sum[N-1:0];
            end else begin
                if (diff[N] || (diff[N-1:0] <= bus.LIMIT)) land    = 1'b1;
                else                                       count_d = diff[N-1:0];
            end

            if (land) begin
                count_d = bus.LIMIT;
                tc_d    = 1'b1;
                if (mode == MODE_ONESHOT) state_d = ST_EXPIRED;
            end
        end else if (active) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= START;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign bus.COUNT   = count_q;
    assign bus.DONE    = (count_q == bus.LIMIT);
    assign bus.TC      = tc_q;
    assign bus.RUNNING = (state_q == ST_RUN);

endmodule

// File: tb/tb_loadable_updown_counter.sv
// Directed checks of loadable_updown_counter across several parameterisations.
module tb_loadable_updown_counter;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    loadable_updown_counter_if #(.N(4)) a_if ();
    loadable_updown_counter_if #(.N(4)) b_if ();
    loadable_updown_counter_if #(.N(4)) c_if ();
    loadable_updown_counter_if #(.N(4)) d_if ();
    loadable_updown_counter_if #(.N(4)) e_if ();

    loadable_updown_counter #(.N(4), .START(4'd0), .STEP(1), .PRESCALE(1))
        u_a (.CLK(clk), .RST_N(rst_n), .bus(a_if));
    loadable_updown_counter #(.N(4), .START(4'd0), .STEP(3), .PRESCALE(1))
        u_b (.CLK(clk), .RST_N(rst_n), .bus(b_if));
    loadable_updown_counter #(.N(4), .START(4'd0), .STEP(2), .PRESCALE(1))
        u_c (.CLK(clk), .RST_N(rst_n), .bus(c_if));
    loadable_updown_counter #(.N(4), .START(4'd0), .STEP(1), .PRESCALE(3))
        u_d (.CLK(clk), .RST_N(rst_n), .bus(d_if));
    loadable_updown_counter #(.N(4), .START(4'd5), .STEP(1), .PRESCALE(1))
        u_e (.CLK(clk), .RST_N(rst_n), .bus(e_if));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_if.LOAD = 1'b1; a_if.LOAD_VAL = 4'd9; a_if.EN = 1'b1;
        e_if.LOAD = 1'b1; e_if.LOAD_VAL = 4'd9;
        step();
        step();
        total++; if (a_if.COUNT !== 4'd0) $display("FAIL reset_count_a got %0d exp 0", a_if.COUNT); else passed++;
        total++; if (a_if.TC !== 1'b0) $display("FAIL reset_tc_a got %b exp 0", a_if.TC); else passed++;
        total++; if (a_if.RUNNING !== 1'b1) $display("FAIL reset_running_a got %b exp 1", a_if.RUNNING); else passed++;
        total++; if (e_if.COUNT !== 4'd5) $display("FAIL reset_count_e got %0d exp 5", e_if.COUNT); else passed++;
        a_if.LOAD = 1'b0; a_if.EN = 1'b0;
        e_if.LOAD = 1'b0;
        rst_n = 1'b1;
        step();
        total++; if (a_if.COUNT !== 4'd0) $display("FAIL post_reset_idle_a got %0d exp 0", a_if.COUNT); else passed++;
    endtask

    task automatic test_wrap();
        a_if.LIMIT = 4'd8; a_if.DIR = 1'b0; a_if.MODE = 2'b00; a_if.EN = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++; if (a_if.COUNT !== 4'(k)) $display("FAIL wrap_count k=%0d got %0d exp %0d", k, a_if.COUNT, k); else passed++;
            total++; if (a_if.TC !== (k == 8)) $display("FAIL wrap_tc k=%0d got %b exp %b", k, a_if.TC, (k == 8)); else passed++;
            total++; if (a_if.DONE !== (k == 8)) $display("FAIL wrap_done k=%0d got %b exp %b", k, a_if.DONE, (k == 8)); else passed++;
        end
        step();
        total++; if (a_if.COUNT !== 4'd0) $display("FAIL wrap_restart got %0d exp 0", a_if.COUNT); else passed++;
        total++; if (a_if.TC !== 1'b0) $display("FAIL wrap_restart_tc got %b exp 0", a_if.TC); else passed++;
        a_if.EN = 1'b0;
    endtask

    task automatic test_clamp_saturate();
        logic [3:0] exp_c [5] = '{4'd3, 4'd6, 4'd7, 4'd7, 4'd7};
        logic       exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        b_if.LIMIT = 4'd7; b_if.DIR = 1'b0; b_if.MODE = 2'b01; b_if.EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (b_if.COUNT !== exp_c[i]) $display("FAIL clamp_count i=%0d got %0d exp %0d", i, b_if.COUNT, exp_c[i]); else passed++;
            total++; if (b_if.TC !== exp_t[i]) $display("FAIL clamp_tc i=%0d got %b exp %b", i, b_if.TC, exp_t[i]); else passed++;
            total++; if (b_if.RUNNING !== 1'b1) $display("FAIL clamp_running i=%0d got %b exp 1", i, b_if.RUNNING); else passed++;
        end
        b_if.EN = 1'b0;
    endtask

    task automatic test_down_oneshot();
        logic [3:0] exp_c [3] = '{4'd3, 4'd1, 4'd0};
        c_if.LOAD = 1'b1; c_if.LOAD_VAL = 4'd5; c_if.DIR = 1'b1;
        c_if.LIMIT = 4'd0; c_if.MODE = 2'b10; c_if.EN = 1'b1;
        step();
        total++; if (c_if.COUNT !== 4'd5) $display("FAIL oneshot_load got %0d exp 5", c_if.COUNT); else passed++;
        c_if.LOAD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (c_if.COUNT !== exp_c[i]) $display("FAIL oneshot_count i=%0d got %0d exp %0d", i, c_if.COUNT, exp_c[i]); else passed++;
            total++; if (c_if.TC !== (i == 2)) $display("FAIL oneshot_tc i=%0d got %b exp %b", i, c_if.TC, (i == 2)); else passed++;
            total++; if (c_if.RUNNING !== (i != 2)) $display("FAIL oneshot_running i=%0d got %b exp %b", i, c_if.RUNNING, (i != 2)); else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (c_if.COUNT !== 4'd0) $display("FAIL oneshot_hold i=%0d got %0d exp 0", i, c_if.COUNT); else passed++;
            total++; if (c_if.TC !== 1'b0) $display("FAIL oneshot_hold_tc i=%0d got %b exp 0", i, c_if.TC); else passed++;
            total++; if (c_if.RUNNING !== 1'b0) $display("FAIL oneshot_expired i=%0d got %b exp 0", i, c_if.RUNNING); else passed++;
        end
        c_if.EN = 1'b0; c_if.CLR = 1'b1;
        step();
        c_if.CLR = 1'b0;
        total++; if (c_if.RUNNING !== 1'b1) $display("FAIL oneshot_clr_running got %b exp 1", c_if.RUNNING); else passed++;
        total++; if (c_if.COUNT !== 4'd0) $display("FAIL oneshot_clr_count got %0d exp 0", c_if.COUNT); else passed++;
    endtask

    task automatic test_prescale();
        logic       en_v  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_c [4] = '{4'd0, 4'd0, 4'd0, 4'd1};
        d_if.LIMIT = 4'd15; d_if.DIR = 1'b0; d_if.MODE = 2'b00;
        for (int i = 0; i < 4; i++) begin
            d_if.EN = en_v[i];
            step();
            total++; if (d_if.COUNT !== exp_c[i]) $display("FAIL prescale_count i=%0d got %0d exp %0d", i, d_if.COUNT, exp_c[i]); else passed++;
            total++; if (d_if.TC !== 1'b0) $display("FAIL prescale_tc i=%0d got %b exp 0", i, d_if.TC); else passed++;
        end
        d_if.EN = 1'b0;
    endtask

    task automatic test_collision();
        a_if.LIMIT = 4'd8; a_if.DIR = 1'b0; a_if.MODE = 2'b00;
        a_if.LOAD = 1'b1; a_if.LOAD_VAL = 4'd7; a_if.EN = 1'b0;
        step();
        total++; if (a_if.COUNT !== 4'd7) $display("FAIL coll_preload got %0d exp 7", a_if.COUNT); else passed++;
        a_if.LOAD_VAL = 4'd2; a_if.EN = 1'b1;
        step();
        total++; if (a_if.COUNT !== 4'd2) $display("FAIL coll_load_count got %0d exp 2", a_if.COUNT); else passed++;
        total++; if (a_if.TC !== 1'b0) $display("FAIL coll_load_tc got %b exp 0", a_if.TC); else passed++;
        a_if.LOAD_VAL = 4'd7;
        step();
        a_if.LOAD = 1'b0; a_if.CLR = 1'b1;
        step();
        total++; if (a_if.COUNT !== 4'd0) $display("FAIL coll_clr_count got %0d exp 0", a_if.COUNT); else passed++;
        total++; if (a_if.TC !== 1'b0) $display("FAIL coll_clr_tc got %b exp 0", a_if.TC); else passed++;
        a_if.CLR = 1'b0; a_if.EN = 1'b0;
    endtask

    task automatic test_wrap_start_and_past_limit();
        e_if.LIMIT = 4'd7; e_if.DIR = 1'b0; e_if.MODE = 2'b11; e_if.EN = 1'b1;
        step();
        total++; if (e_if.COUNT !== 4'd6) $display("FAIL wst_count6 got %0d exp 6", e_if.COUNT); else passed++;
        step();
        total++; if (e_if.COUNT !== 4'd7 || e_if.TC !== 1'b1) $display("FAIL wst_land got %0d/%b exp 7/1", e_if.COUNT, e_if.TC); else passed++;
        step();
        total++; if (e_if.COUNT !== 4'd5 || e_if.TC !== 1'b0) $display("FAIL wst_to_start got %0d/%b exp 5/0", e_if.COUNT, e_if.TC); else passed++;
        e_if.EN = 1'b0; e_if.LOAD = 1'b1; e_if.LOAD_VAL = 4'd9; e_if.MODE = 2'b01;
        step();
        e_if.LOAD = 1'b0; e_if.EN = 1'b1;
        step();
        total++; if (e_if.COUNT !== 4'd9 || e_if.TC !== 1'b0) $display("FAIL past_sat got %0d/%b exp 9/0", e_if.COUNT, e_if.TC); else passed++;
        e_if.MODE = 2'b00;
        step();
        total++; if (e_if.COUNT !== 4'd5 || e_if.TC !== 1'b0) $display("FAIL past_wrap got %0d/%b exp 5/0", e_if.COUNT, e_if.TC); else passed++;
        e_if.EN = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        a_if.LIMIT = 4'd8; a_if.MODE = 2'b00; a_if.DIR = 1'b0;
        a_if.LOAD = 1'b1; a_if.LOAD_VAL = 4'd4; a_if.EN = 1'b0;
        d_if.EN = 1'b1;
        step();
        a_if.LOAD = 1'b0; a_if.EN = 1'b1; d_if.EN = 1'b0;
        step();
        step();
        total++; if (a_if.COUNT !== 4'd6) $display("FAIL rmid_pre got %0d exp 6", a_if.COUNT); else passed++;
        total++; if (d_if.COUNT !== 4'd1) $display("FAIL rmid_pre_d got %0d exp 1", d_if.COUNT); else passed++;
        rst_n = 1'b0; d_if.EN = 1'b1;
        step();
        total++; if (a_if.COUNT !== 4'd0) $display("FAIL rmid_count got %0d exp 0", a_if.COUNT); else passed++;
        total++; if (a_if.TC !== 1'b0) $display("FAIL rmid_tc got %b exp 0", a_if.TC); else passed++;
        total++; if (a_if.RUNNING !== 1'b1) $display("FAIL rmid_running got %b exp 1", a_if.RUNNING); else passed++;
        total++; if (d_if.COUNT !== 4'd0) $display("FAIL rmid_count_d got %0d exp 0", d_if.COUNT); else passed++;
        rst_n = 1'b1;
        step();
        total++; if (a_if.COUNT !== 4'd1) $display("FAIL rmid_resume got %0d exp 1", a_if.COUNT); else passed++;
        step();
        total++; if (d_if.COUNT !== 4'd0) $display("FAIL rmid_prescale_cleared got %0d exp 0", d_if.COUNT); else passed++;
        step();
        total++; if (d_if.COUNT !== 4'd1) $display("FAIL rmid_prescale_tick got %0d exp 1", d_if.COUNT); else passed++;
        a_if.EN = 1'b0; d_if.EN = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_if.EN = 1'b0; a_if.CLR = 1'b0; a_if.LOAD = 1'b0; a_if.LOAD_VAL = '0;
        a_if.LIMIT = 4'd8; a_if.DIR = 1'b0; a_if.MODE = 2'b00;
        b_if.EN = 1'b0; b_if.CLR = 1'b0; b_if.LOAD = 1'b0; b_if.LOAD_VAL = '0;
        b_if.LIMIT = 4'd7; b_if.DIR = 1'b0; b_if.MODE = 2'b01;
        c_if.EN = 1'b0; c_if.CLR = 1'b0; c_if.LOAD = 1'b0; c_if.LOAD_VAL = '0;
        c_if.LIMIT = 4'd0; c_if.DIR = 1'b1; c_if.MODE = 2'b10;
        d_if.EN = 1'b0; d_if.CLR = 1'b0; d_if.LOAD = 1'b0; d_if.LOAD_VAL = '0;
        d_if.LIMIT = 4'd15; d_if.DIR = 1'b0; d_if.MODE = 2'b00;
        e_if.EN = 1'b0; e_if.CLR = 1'b0; e_if.LOAD = 1'b0; e_if.LOAD_VAL = '0;
        e_if.LIMIT = 4'd7; e_if.DIR = 1'b0; e_if.MODE = 2'b11;

        test_reset();
        test_wrap();
        test_clamp_saturate();
        test_down_oneshot();
        test_prescale();
        test_collision();
        test_wrap_start_and_past_limit();
        test_reset_mid_run();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/loadable_updown_counter.md
LOADABLE_UPDOWN_COUNTER -- requirements
Module: loadable_updown_counter

Interface
REQ-001 Parameter N, default 4, SHALL set the counter width in bits (N >= 2).
REQ-002 Parameter START, default 0, SHALL set the reset, clear and wrap value (N bits).
REQ-003 Parameter STEP, default 1, SHALL set the unsigned step magnitude (1 <= STEP < 2^N); direction comes from DIR.
REQ-004 Parameter PRESCALE, default 1, SHALL set how many enabled cycles make one count tick (PRESCALE >= 1).
REQ-005 CLK  input  1  SHALL be the clock; all state updates on its posedge.
REQ-006 RST_N  input  1  SHALL be the synchronous, active-low reset.
REQ-007 EN  input  1  SHALL be the count enable.
REQ-008 CLR  input  1  SHALL synchronously restore START.
REQ-009 LOAD  input  1  SHALL load LOAD_VAL.
REQ-010 LOAD_VAL  input  N  SHALL be the load value.
REQ-011 LIMIT  input  N  SHALL be the terminal value, sampled every cycle.
REQ-012 DIR  input  1  SHALL select up (0) or down (1).
REQ-013 MODE  input  2  SHALL select 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-014 COUNT  output  N  SHALL be the registered current count.
REQ-015 DONE  output  1  SHALL be the combinational flag (COUNT == LIMIT).
REQ-016 TC  output  1  SHALL be the registered one-cycle terminal-count pulse.
REQ-017 RUNNING  output  1  SHALL be the registered flag; 0 means one-shot expired.

Function
REQ-018 Priority SHALL be, highest first: RST_N low, CLR, LOAD, tick.
REQ-019 CLR SHALL set COUNT=START, prescaler=0, RUNNING=1 and TC=0 on the next edge.
REQ-020 LOAD SHALL set COUNT=LOAD_VAL, prescaler=0, RUNNING=1 and TC=0 on the next edge.
REQ-021 The prescaler SHALL count 0..PRESCALE-1 on cycles with EN=1 and RUNNING=1; a tick occurs when it equals PRESCALE-1, and it then returns to 0.
REQ-022 With EN=0 or RUNNING=0, COUNT and the prescaler SHALL hold.
REQ-023 An up tick SHALL compute COUNT+STEP in N+1 bits; a result >= LIMIT SHALL clamp COUNT to LIMIT, otherwise COUNT takes the sum.
REQ-024 A down tick SHALL compute COUNT-STEP in N+1 bits; a borrow or a result <= LIMIT SHALL clamp COUNT to LIMIT, otherwise COUNT takes the difference.
REQ-025 A tick that moves COUNT from a value != LIMIT onto LIMIT SHALL assert TC for exactly the next cycle; TC is 0 at all other times.
REQ-026 A tick while COUNT == LIMIT SHALL act by mode: wrap sets COUNT=START with no TC; saturate holds with no TC.
REQ-027 A tick while COUNT is already past LIMIT in the counting direction (up: COUNT > LIMIT; down: COUNT < LIMIT) SHALL act as if COUNT == LIMIT, with no clamp write and no TC.
REQ-028 In one-shot mode, the tick that lands on LIMIT SHALL clear RUNNING together with asserting TC; only CLR, LOAD or reset SHALL set RUNNING again.
REQ-029 Changing MODE, DIR or LIMIT mid-count SHALL take effect on the next tick with no other side effect.
REQ-030 CLR or LOAD in the same cycle as a tick SHALL win, and that tick SHALL be discarded (no TC).
REQ-031 TC latency SHALL be 0 cycles after the landing edge: TC and COUNT=LIMIT become visible together.

Reset
REQ-032 With RST_N=0 at a posedge: COUNT=START, TC=0, RUNNING=1, prescaler=0; all other inputs ignored.
REQ-033 Reset asserted mid-count or mid-prescale SHALL discard all progress; counting resumes from START on the first enabled cycle after RST_N=1.

Verification
REQ-034 Wrap, N=4, START=0, STEP=1, PRESCALE=1, LIMIT=8, DIR=0, EN=1 -> COUNT 0..8; TC high with COUNT=8; DONE=1; next cycle COUNT=0, TC=0.
REQ-035 Clamp, STEP=3, LIMIT=7, saturate -> COUNT 0,3,6,7,7,...; TC single pulse at 7; RUNNING stays 1.
REQ-036 Down one-shot, LOAD_VAL=5, DIR=1, LIMIT=0, STEP=2 -> COUNT 5,3,1,0; TC and RUNNING=0 at 0; COUNT holds despite EN=1 until CLR.
REQ-037 Prescale, PRESCALE=3, EN toggled 1,1,0,1 -> one tick on the 4th cycle only; COUNT 0 to 1.
REQ-038 Collision, LOAD=1 with LOAD_VAL=2 on the landing tick -> COUNT=2, TC=0.
REQ-039 Reset mid-run, RST_N=0 for 1 cycle at COUNT=6 -> COUNT=START, TC=0, RUNNING=1.
